// File: rtl/i2c_master_write.sv
// Single-master I2C write initiator: START, 7-bit address + W, streamed data bytes, STOP.
// Open-drain drive: *_oe=1 pulls the line low, 0 releases it.
module i2c_master_write #(
   parameter int CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_start,
   input  logic [6:0] cmd_addr,
   input  logic [7:0] tx_data,
   input  logic       tx_last,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       sda_in,
   input  logic       scl_in,
   output logic       sda_oe,
   output logic       scl_oe,
   output logic       busy,
   output logic       done,
   output logic       nack
);

   localparam int CW = $clog2(2 * CLK_DIV);
   localparam logic [CW-1:0] Q_END = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] H_END = CW'(2 * CLK_DIV - 1);

   typedef enum logic [3:0] {
      IDLE, START, ADDR, ACK_A, WAIT_DATA, DATA, ACK_D, STOP, STOP_HOLD
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [1:0]    q;
   logic [2:0]    bit_cnt;
   logic [7:0]    shreg;
   logic          last_byte;
   logic          ack_bit;
   logic          stretch;

   // The SCL-high quarter only counts while the bus actually shows SCL high.
   assign stretch = (q == 2'd2) && !scl_in;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         q         <= 2'd0;
         bit_cnt   <= 3'd0;
         shreg     <= 8'd0;
         last_byte <= 1'b0;
         ack_bit   <= 1'b0;
         sda_oe    <= 1'b0;
         scl_oe    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         nack      <= 1'b0;
         tx_ready  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               // the done cycle still reads as IDLE, so a start there is refused
               if (cmd_start && !done) begin
                  shreg  <= {cmd_addr, 1'b0};
                  busy   <= 1'b1;
                  nack   <= 1'b0;
                  sda_oe <= 1'b1;
                  cnt    <= '0;
                  state  <= START;
               end
            end
            START: begin
               if (cnt == H_END) begin
                  cnt     <= '0;
                  q       <= 2'd0;
                  bit_cnt <= 3'd0;
                  scl_oe  <= 1'b1;
                  sda_oe  <= ~shreg[7];
                  state   <= ADDR;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            WAIT_DATA: begin
               if (tx_valid) begin
                  shreg     <= tx_data;
                  last_byte <= tx_last;
                  tx_ready  <= 1'b0;
                  sda_oe    <= ~tx_data[7];
                  q         <= 2'd0;
                  cnt       <= '0;
                  bit_cnt   <= 3'd0;
                  state     <= DATA;
               end
            end
            STOP_HOLD: begin
               if (cnt == H_END) begin
                  cnt   <= '0;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               if ((state == ACK_A || state == ACK_D) && q == 2'd3 && cnt == '0) begin
                  ack_bit <= sda_in;
                  if (sda_in) nack <= 1'b1;
               end
               if (!stretch) begin
                  if (cnt != Q_END) begin
                     cnt <= cnt + 1'b1;
                  end else begin
                     cnt <= '0;
                     q   <= q + 2'd1;
                     if (q == 2'd1) scl_oe <= 1'b0;
                     if (q == 2'd3) begin
                        scl_oe <= 1'b1;
                        case (state)
                           ADDR, DATA: begin
                              bit_cnt <= bit_cnt + 3'd1;
                              if (bit_cnt == 3'd7) begin
                                 sda_oe <= 1'b0;
                                 state  <= (state == ADDR) ? ACK_A : ACK_D;
                              end else begin
                                 sda_oe <= ~shreg[6];
                                 shreg  <= {shreg[6:0], 1'b0};
                              end
                           end
                           ACK_A, ACK_D: begin
                              if (ack_bit || (state == ACK_D && last_byte)) begin
                                 sda_oe <= 1'b1;
                                 state  <= STOP;
                              end else begin
                                 tx_ready <= 1'b1;
                                 state    <= WAIT_DATA;
                              end
                           end
                           STOP: begin
                              // SDA rises with SCL high: the STOP condition
                              scl_oe <= 1'b0;
                              sda_oe <= 1'b0;
                              state  <= STOP_HOLD;
                           end
                           default: ;
                        endcase
                     end
                  end
               end
            end
         endcase
      end
   end

endmodule
